// File: rtl/ifft_out_serializer.sv
// Two-bank capture buffer that reorders an 8-point IFFT vector (bit-reversed -> natural)
// and streams it one complex sample per valid/ready beat. Define IFFT_OUT_SCALE_EN for 1/8 rounding scale.
module ifft_out_serializer #(
  parameter int DW     = 16,
  parameter bit BITREV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [8*DW-1:0] in_re,
  input  logic [8*DW-1:0] in_im,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_re,
  output logic [DW-1:0]   out_im,
  output logic [2:0]      out_idx,
  output logic            out_last,
  output logic            ovf_err
);

  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, rd_ptr_q;
  logic [2:0]      k_q;
  logic            ovf_q;
  logic [8*DW-1:0] bank_re_q [2];
  logic [8*DW-1:0] bank_im_q [2];

  logic            accept, beat, release_bank;
  logic [2:0]      sel;
  logic [DW-1:0]   elem_re, elem_im;

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] s);
`ifdef IFFT_OUT_SCALE_EN
    logic signed [DW:0] t;
    // One guard bit keeps s + 4 from wrapping near the positive limit.
    t = $signed({s[DW-1], s}) + $signed((DW+1)'(4));
    t = t >>> 3;
    return t[DW-1:0];
`else
    return s;
`endif
  endfunction

  assign in_ready     = (count_q < 2'd2);
  assign out_valid    = (count_q != 2'd0);
  assign accept       = in_valid & in_ready;
  assign beat         = out_valid & out_ready;
  assign release_bank = beat & (k_q == 3'd7);

  always_comb begin
    count_d = count_q;
    case ({accept, release_bank})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      k_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (beat) k_q <= k_q + 3'd1;
      if (release_bank) rd_ptr_q <= ~rd_ptr_q;
      if (in_valid && !in_ready) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && accept) begin
      bank_re_q[wr_ptr_q] <= in_re;
      bank_im_q[wr_ptr_q] <= in_im;
    end
  end

  assign sel     = BITREV ? {k_q[0], k_q[1], k_q[2]} : k_q;
  assign elem_re = bank_re_q[rd_ptr_q][sel*DW +: DW];
  assign elem_im = bank_im_q[rd_ptr_q][sel*DW +: DW];

  assign out_re   = out_valid ? scale(elem_re) : '0;
  assign out_im   = out_valid ? scale(elem_im) : '0;
  assign out_idx  = k_q;
  assign out_last = (k_q == 3'd7);
  assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_ifft_out_serializer.sv
// Self-checking bench for ifft_out_serializer: directed tables, corner sequences and a
// queue-based reference model compared every cycle under random traffic.
module tb_ifft_out_serializer;
  localparam int DW = 16;
  localparam bit BITREV = 1'b1;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [8*DW-1:0] in_re, in_im;
  logic            in_ready, out_valid, out_ready;
  logic [DW-1:0]   out_re, out_im;
  logic [2:0]      out_idx;
  logic            out_last, ovf_err;

  always #5 clk = ~clk;

  ifft_out_serializer #(.DW(DW), .BITREV(BITREV)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last),
    .ovf_err(ovf_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned brev(input int unsigned k);
    logic [2:0] b;
    b = k[2:0];
    return BITREV ? int'({b[0], b[1], b[2]}) : int'(b);
  endfunction

  function automatic logic [DW-1:0] ref_scale(input logic [DW-1:0] s);
`ifdef IFFT_OUT_SCALE_EN
    int v;
    v = int'($signed(s));
    v = (v + 4) >>> 3;
    return v[DW-1:0];
`else
    return s;
`endif
  endfunction

  function automatic logic [DW-1:0] elem(input logic [8*DW-1:0] v, input int unsigned i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [8*DW-1:0] rnd_vec();
    logic [8*DW-1:0] v;
    for (int unsigned i = 0; i < 8; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Reference model: a FIFO of whole vectors plus the beat index into the head vector.
  logic [8*DW-1:0] mq_re[$];
  logic [8*DW-1:0] mq_im[$];
  int unsigned     mk = 0;
  logic            m_ovf = 1'b0;
  int unsigned     m_pre;
  bit              m_rel;

  always @(posedge clk) begin
    if (!reset) begin
      mq_re.delete(); mq_im.delete(); mk = 0; m_ovf = 1'b0;
    end else begin
      m_pre = mq_re.size();
      m_rel = 0;
      if (m_pre != 0 && out_ready) begin
        if (mk == 7) begin mk = 0; m_rel = 1; end
        else mk = mk + 1;
      end
      if (m_rel) begin void'(mq_re.pop_front()); void'(mq_im.pop_front()); end
      if (in_valid) begin
        if (m_pre < 2) begin mq_re.push_back(in_re); mq_im.push_back(in_im); end
        else m_ovf = 1'b1;
      end
    end
  end

  bit              mon_en = 0;
  bit              m_v;
  logic [DW-1:0]   m_er, m_ei;
  always @(negedge clk) begin
    if (mon_en) begin
      m_v = (mq_re.size() != 0);
      m_er = m_v ? ref_scale(elem(mq_re[0], brev(mk))) : '0;
      m_ei = m_v ? ref_scale(elem(mq_im[0], brev(mk))) : '0;
      chk("mon_out_valid", out_valid, m_v);
      chk("mon_in_ready", in_ready, mq_re.size() < 2);
      chk("mon_ovf_err", ovf_err, m_ovf);
      chk("mon_out_idx", out_idx, mk);
      chk("mon_out_last", out_last, mk == 7);
      chk("mon_out_re", out_re, m_er);
      chk("mon_out_im", out_im, m_ei);
    end
  end

  task automatic put_vec(input logic [8*DW-1:0] re, input logic [8*DW-1:0] im);
    in_re = re; in_im = im; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]    idx;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } vrec_t;

  vrec_t           tbl[8];
  int              tre[8] = '{0, 64, 32, 96, 16, 80, 48, 112};
  int              tim[8] = '{0, -4, -2, -6, -1, -5, -3, -7};
  logic [8*DW-1:0] va_re, va_im, vb_re, vb_im, vc_re, vc_im;
  logic [DW-1:0]   sc_exp[4];
  int              beats;

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
    mon_en = 1;

    // Reset hold with a vector presented throughout.
    in_valid = 1'b1; in_re = rnd_vec(); in_im = rnd_vec();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_ovf_err", ovf_err, 0);
      chk("rst_out_re", out_re, 0);
      chk("rst_out_idx", out_idx, 0);
    end
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_no_bank_written", out_valid, 0);

    // Single vector, table of expected natural-order beats.
    for (int j = 0; j < 8; j++) begin
      tbl[j].idx  = 3'(j);
      tbl[j].re   = ref_scale(DW'(tre[j]));
      tbl[j].im   = ref_scale(DW'(tim[j]));
      tbl[j].last = (j == 7);
    end
    for (int i = 0; i < 8; i++) begin
      va_re[i*DW +: DW] = DW'(16 * i);
      va_im[i*DW +: DW] = DW'(-i);
    end
    out_ready = 1'b1;
    chk("single_pre_valid", out_valid, 0);
    put_vec(va_re, va_im);
    chk("single_first_valid", out_valid, 1);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("single_idx%0d", j), out_idx, tbl[j].idx);
      chk($sformatf("single_re%0d", j), out_re, tbl[j].re);
      chk($sformatf("single_im%0d", j), out_im, tbl[j].im);
      chk($sformatf("single_last%0d", j), out_last, tbl[j].last);
      @(negedge clk);
    end
    chk("single_done_valid", out_valid, 0);

    // Backpressure pattern 1,0,0,1 during the drain.
    out_ready = 1'b0;
    va_re = rnd_vec(); va_im = rnd_vec();
    put_vec(va_re, va_im);
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      if (out_valid && out_ready) begin
        chk("bp_idx", out_idx, beats);
        chk("bp_re", out_re, ref_scale(elem(va_re, brev(beats))));
        beats++;
      end
      @(negedge clk);
    end
    chk("bp_beat_count", beats, 8);
    chk("bp_done_valid", out_valid, 0);

    // Overflow: three vectors back to back while the sink is stalled.
    out_ready = 1'b0;
    va_re = rnd_vec(); va_im = rnd_vec();
    vb_re = rnd_vec(); vb_im = rnd_vec();
    vc_re = rnd_vec(); vc_im = rnd_vec();
    put_vec(va_re, va_im);
    put_vec(vb_re, vb_im);
    put_vec(vc_re, vc_im);
    chk("ovf_in_ready", in_ready, 0);
    chk("ovf_flag", ovf_err, 1);
    out_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      chk("ovf_drain_valid", out_valid, 1);
      chk($sformatf("ovf_drain_re%0d", b), out_re,
          ref_scale(elem(b < 8 ? va_re : vb_re, brev(b % 8))));
      @(negedge clk);
    end
    chk("ovf_drained", out_valid, 0);
    chk("ovf_sticky", ovf_err, 1);

    // Back-to-back: new vector lands on the final beat of the current one.
    va_re = rnd_vec(); va_im = rnd_vec();
    vb_re = rnd_vec(); vb_im = rnd_vec();
    put_vec(va_re, va_im);
    for (int c = 0; c < 20 && out_idx != 3'd7; c++) @(negedge clk);
    chk("b2b_reach_last", out_idx, 7);
    put_vec(vb_re, vb_im);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_idx", out_idx, 0);
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_re", out_re, ref_scale(elem(vb_re, brev(0))));
    repeat (8) @(negedge clk);
    chk("b2b_done_valid", out_valid, 0);

    // Scaling corner samples at beats 0..3 (elements 0,4,2,6).
`ifdef IFFT_OUT_SCALE_EN
    sc_exp = '{16'h1000, 16'hFFFF, 16'h0000, 16'h0000};
`else
    sc_exp = '{16'h7FFF, 16'hFFFB, 16'hFFFC, 16'h0003};
`endif
    va_re = '0;
    va_re[0*DW +: DW] = 16'h7FFF;
    va_re[4*DW +: DW] = 16'hFFFB;
    va_re[2*DW +: DW] = 16'hFFFC;
    va_re[6*DW +: DW] = 16'h0003;
    put_vec(va_re, va_re);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("scale_re%0d", b), out_re, sc_exp[b]);
      chk($sformatf("scale_im%0d", b), out_im, sc_exp[b]);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // Reset mid-drain discards the vector and clears the sticky flag.
    put_vec(rnd_vec(), rnd_vec());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ovf", ovf_err, 0);
    @(negedge clk);
    chk("midrst_still_idle", out_valid, 0);

    // Full throughput: a vector every 8 cycles with the sink always ready.
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      put_vec(rnd_vec(), rnd_vec());
      repeat (7) @(negedge clk);
    end
    chk("thru_no_drop", ovf_err, 0);
    repeat (10) @(negedge clk);

    // Random traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_re     = rnd_vec();
      in_im     = rnd_vec();
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
